// File: rtl/rcv_cmd_sequencer_pkg.sv
// Shared constants for the receive command sequencer:
// sync byte, FSM state encodings and error codes.
package rcv_cmd_sequencer_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam logic [2:0] ST_HUNT  = 3'd0;
    localparam logic [2:0] ST_OPC   = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_PAY   = 3'd3;
    localparam logic [2:0] ST_CSUM  = 3'd4;
    localparam logic [2:0] ST_ISSUE = 3'd5;

    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;
    localparam logic [1:0] ERR_TO   = 2'b11;

endpackage

// File: rtl/rcv_byte_fetch.sv
// Receive FIFO pop handshake (one pop in flight) and the
// inter-byte timeout counter used while inside a frame.
module rcv_byte_fetch #(
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_dout,
    output logic       fifo_rd_en,
    input  logic       fetch_en,
    input  logic       in_frame,
    output logic       byte_v,
    output logic [7:0] byte_data,
    output logic       timeout
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic          rd_pend_q;
    logic [TW-1:0] to_cnt_q;
    logic [TW-1:0] to_cnt_d;

    assign fifo_rd_en = rst & fetch_en & ~fifo_empty & ~rd_pend_q;
    assign byte_v     = rd_pend_q;
    assign byte_data  = fifo_dout;

    // A byte landing on the terminal count wins over the timeout.
    assign timeout = in_frame & ~rd_pend_q & (to_cnt_q == TO_LAST);

    always_comb begin
        to_cnt_d = to_cnt_q + TW'(1);
        if (!in_frame || rd_pend_q || timeout) begin
            to_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend_q <= 1'b0;
            to_cnt_q  <= '0;
        end else begin
            rd_pend_q <= fifo_rd_en;
            to_cnt_q  <= to_cnt_d;
        end
    end

endmodule

// File: rtl/rcv_cmd_sequencer.sv
// Frames received bytes into commands: SYNC, OPCODE, LEN,
// payload, XOR checksum; payload goes to a local buffer.
module rcv_cmd_sequencer
    import rcv_cmd_sequencer_pkg::*;
#(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 50000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fifo_empty,
    input  logic [7:0]    fifo_dout,
    output logic          fifo_rd_en,
    output logic          pl_we,
    output logic [AW-1:0] pl_addr,
    output logic [7:0]    pl_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_opcode,
    output logic [7:0]    cmd_len,
    output logic          err_pulse,
    output logic [1:0]    err_code,
    output logic [7:0]    pkt_cnt,
    output logic [7:0]    err_cnt
);

    logic [2:0]    state_q, state_d;
    logic [7:0]    opc_q, opc_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    csum_q, csum_d;
    logic [AW-1:0] idx_q, idx_d;
    logic          pl_we_q, pl_we_d;
    logic [AW-1:0] pl_addr_q, pl_addr_d;
    logic [7:0]    pl_data_q, pl_data_d;
    logic          err_pulse_q, err_pulse_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [7:0]    pkt_q, pkt_d;
    logic [7:0]    errc_q, errc_d;

    logic          fetch_en;
    logic          in_frame;
    logic          byte_v;
    logic [7:0]    byte_data;
    logic          timeout;
    logic          err_hit;
    logic [1:0]    err_sel;

    assign fetch_en = (state_q != ST_ISSUE);
    assign in_frame = (state_q == ST_OPC) || (state_q == ST_LEN) ||
                      (state_q == ST_PAY) || (state_q == ST_CSUM);

    rcv_byte_fetch #(
        .TIMEOUT(TIMEOUT)
    ) u_fetch (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .fetch_en  (fetch_en),
        .in_frame  (in_frame),
        .byte_v    (byte_v),
        .byte_data (byte_data),
        .timeout   (timeout)
    );

    always_comb begin
        state_d     = state_q;
        opc_d       = opc_q;
        len_d       = len_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        pl_we_d     = 1'b0;
        pl_addr_d   = pl_addr_q;
        pl_data_d   = pl_data_q;
        err_pulse_d = 1'b0;
        err_code_d  = err_code_q;
        pkt_d       = pkt_q;
        errc_d      = errc_q;
        err_hit     = 1'b0;
        err_sel     = ERR_LEN;

        if (timeout) begin
            err_hit = 1'b1;
            err_sel = ERR_TO;
            state_d = ST_HUNT;
        end else begin
            unique case (state_q)
                ST_HUNT: begin
                    if (byte_v && byte_data == SYNC_BYTE) state_d = ST_OPC;
                end
                ST_OPC: begin
                    if (byte_v) begin
                        opc_d   = byte_data;
                        csum_d  = byte_data;
                        state_d = ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (byte_v) begin
                        if (byte_data > 8'(MAX_LEN)) begin
                            err_hit = 1'b1;
                            err_sel = ERR_LEN;
                            state_d = ST_HUNT;
                        end else begin
                            len_d   = byte_data;
                            csum_d  = csum_q ^ byte_data;
                            idx_d   = '0;
                            state_d = (byte_data == 8'd0) ? ST_CSUM : ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    if (byte_v) begin
                        pl_we_d   = 1'b1;
                        pl_addr_d = idx_q;
                        pl_data_d = byte_data;
                        csum_d    = csum_q ^ byte_data;
                        idx_d     = idx_q + AW'(1);
                        if (8'(idx_q) == len_q - 8'd1) state_d = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    if (byte_v) begin
                        if (byte_data == csum_q) begin
                            state_d = ST_ISSUE;
                        end else begin
                            err_hit = 1'b1;
                            err_sel = ERR_CSUM;
                            state_d = ST_HUNT;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        if (pkt_q != 8'hFF) pkt_d = pkt_q + 8'd1;
                        state_d = ST_HUNT;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (err_hit) begin
            err_pulse_d = 1'b1;
            err_code_d  = err_sel;
            if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_HUNT;
            opc_q       <= '0;
            len_q       <= '0;
            csum_q      <= '0;
            idx_q       <= '0;
            pl_we_q     <= 1'b0;
            pl_addr_q   <= '0;
            pl_data_q   <= '0;
            err_pulse_q <= 1'b0;
            err_code_q  <= '0;
            pkt_q       <= '0;
            errc_q      <= '0;
        end else begin
            state_q     <= state_d;
            opc_q       <= opc_d;
            len_q       <= len_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            pl_we_q     <= pl_we_d;
            pl_addr_q   <= pl_addr_d;
            pl_data_q   <= pl_data_d;
            err_pulse_q <= err_pulse_d;
            err_code_q  <= err_code_d;
            pkt_q       <= pkt_d;
            errc_q      <= errc_d;
        end
    end

    assign pl_we      = pl_we_q;
    assign pl_addr    = pl_addr_q;
    assign pl_data    = pl_data_q;
    assign cmd_valid  = (state_q == ST_ISSUE);
    assign cmd_opcode = opc_q;
    assign cmd_len    = len_q;
    assign err_pulse  = err_pulse_q;
    assign err_code   = err_code_q;
    assign pkt_cnt    = pkt_q;
    assign err_cnt    = errc_q;

endmodule

// File: tb/tb_rcv_cmd_sequencer.sv
// Directed bench for rcv_cmd_sequencer with a simple
// array-backed receive FIFO model.
module tb_rcv_cmd_sequencer;

    localparam int TIMEOUT = 50000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       pl_we;
    logic [3:0] pl_addr;
    logic [7:0] pl_data;
    logic       cmd_valid;
    logic       cmd_ready = 1'b1;
    logic [7:0] cmd_opcode;
    logic [7:0] cmd_len;
    logic       err_pulse;
    logic [1:0] err_code;
    logic [7:0] pkt_cnt;
    logic [7:0] err_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [0:2047];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    rcv_cmd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .fifo_empty(fifo_empty),
        .fifo_dout (fifo_dout),
        .fifo_rd_en(fifo_rd_en),
        .pl_we     (pl_we),
        .pl_addr   (pl_addr),
        .pl_data   (pl_data),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_opcode(cmd_opcode),
        .cmd_len   (cmd_len),
        .err_pulse (err_pulse),
        .err_code  (err_code),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        settle(3);
        checks++;
        if ({fifo_rd_en, pl_we, pl_addr, pl_data, cmd_valid, cmd_opcode,
             cmd_len, err_pulse, err_code, pkt_cnt, err_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero outputs, required all zero");
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_good_frame();
        logic [7:0] wa [0:7];
        logic [7:0] wd [0:7];
        int nw = 0;
        int nv = 0;
        int ne = 0;
        logic [7:0] opc = 8'h00;
        logic [7:0] len = 8'h00;
        cmd_ready = 1'b1;
        push(8'hA5); push(8'h10); push(8'h03);
        push(8'h01); push(8'h02); push(8'h03); push(8'h13);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pl_we && nw < 8) begin
                wa[nw] = 8'(pl_addr);
                wd[nw] = pl_data;
                nw++;
            end
            if (cmd_valid) begin
                nv++;
                opc = cmd_opcode;
                len = cmd_len;
            end
            if (err_pulse) ne++;
        end
        checks++;
        if (nw !== 3) begin
            errors++;
            $display("FAIL good_nwrites: got %0d required 3", nw);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (k < nw && (wa[k] !== 8'(k) || wd[k] !== 8'(k + 1))) begin
                errors++;
                $display("FAIL good_write%0d: got addr %0h data %0h required %0h %0h",
                         k, wa[k], wd[k], k, k + 1);
            end
        end
        checks++;
        if (nv !== 1 || opc !== 8'h10 || len !== 8'h03) begin
            errors++;
            $display("FAIL good_cmd: got valid_cycles %0d opc %0h len %0h required 1 10 3",
                     nv, opc, len);
        end
        checks++;
        if (pkt_cnt !== 8'd1 || err_cnt !== 8'd0 || ne !== 0) begin
            errors++;
            $display("FAIL good_counts: got pkt %0d err %0d pulses %0d required 1 0 0",
                     pkt_cnt, err_cnt, ne);
        end
    endtask

    task automatic test_back_to_back();
        int found = 0;
        int bad = 0;
        int ne = 0;
        cmd_ready = 1'b0;
        push(8'h00); push(8'hFF); push(8'hA5); push(8'h20);
        push(8'h00); push(8'h20); push(8'h00);
        for (int i = 0; i < 60 && found == 0; i++) begin
            tick();
            if (err_pulse) ne++;
            if (cmd_valid) found = 1;
        end
        checks++;
        if (found !== 1) begin
            errors++;
            $display("FAIL bp_valid_seen: got %0d required 1", found);
        end
        for (int i = 0; i < 10; i++) begin
            if (!cmd_valid || cmd_opcode !== 8'h20 || cmd_len !== 8'h00 || fifo_rd_en)
                bad++;
            if (err_pulse) ne++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold: got %0d bad cycles required 0", bad);
        end
        cmd_ready = 1'b1;
        tick();
        checks++;
        if (cmd_valid !== 1'b0 || pkt_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bp_issue: got valid %0b pkt %0d required 0 2", cmd_valid, pkt_cnt);
        end
        settle(10);
        checks++;
        if (ne !== 0 || err_cnt !== 8'd0 || pkt_cnt !== 8'd2) begin
            errors++;
            $display("FAIL bp_junk_dropped: got pulses %0d err %0d pkt %0d required 0 0 2",
                     ne, err_cnt, pkt_cnt);
        end
    endtask

    task automatic test_bad_csum();
        int ne = 0;
        int nv = 0;
        push(8'hA5); push(8'h11); push(8'h02);
        push(8'hAA); push(8'hBB); push(8'h00);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (err_pulse) ne++;
            if (cmd_valid) nv++;
        end
        checks++;
        if (ne !== 1 || err_code !== 2'b10 || err_cnt !== 8'd1 || nv !== 0) begin
            errors++;
            $display("FAIL csum_err: got pulses %0d code %0b errcnt %0d valid %0d required 1 10 1 0",
                     ne, err_code, err_cnt, nv);
        end
    endtask

    task automatic test_len_error();
        int ne = 0;
        int nw = 0;
        int nw_at_err = -1;
        int nv = 0;
        logic [1:0] code_at_err = 2'b00;
        logic [7:0] wd = 8'h00;
        logic [7:0] opc = 8'h00;
        logic [7:0] len = 8'h00;
        push(8'hA5); push(8'h12); push(8'h11);
        push(8'hA5); push(8'h21); push(8'h01); push(8'h5A); push(8'h7A);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (err_pulse) begin
                ne++;
                nw_at_err = nw;
                code_at_err = err_code;
            end
            if (pl_we) begin
                nw++;
                wd = pl_data;
            end
            if (cmd_valid) begin
                nv++;
                opc = cmd_opcode;
                len = cmd_len;
            end
        end
        checks++;
        if (ne !== 1 || code_at_err !== 2'b01 || nw_at_err !== 0) begin
            errors++;
            $display("FAIL len_err: got pulses %0d code %0b writes_before %0d required 1 01 0",
                     ne, code_at_err, nw_at_err);
        end
        checks++;
        if (nv !== 1 || opc !== 8'h21 || len !== 8'h01 || nw !== 1 || wd !== 8'h5A) begin
            errors++;
            $display("FAIL len_next_frame: got valid %0d opc %0h len %0h writes %0d data %0h required 1 21 1 1 5a",
                     nv, opc, len, nw, wd);
        end
        checks++;
        if (pkt_cnt !== 8'd3 || err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL len_counts: got pkt %0d err %0d required 3 2", pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        int hit = 0;
        int nv = 0;
        logic [7:0] opc = 8'h00;
        push(8'hA5); push(8'h13);
        for (int i = 1; i <= TIMEOUT + 20 && hit == 0; i++) begin
            tick();
            if (err_pulse) begin
                hit = 1;
                n = i;
            end
        end
        checks++;
        if (hit !== 1 || n !== TIMEOUT + 4) begin
            errors++;
            $display("FAIL timeout_cycle: got hit %0d at %0d required 1 at %0d",
                     hit, n, TIMEOUT + 4);
        end
        checks++;
        if (err_code !== 2'b11 || err_cnt !== 8'd3) begin
            errors++;
            $display("FAIL timeout_code: got code %0b errcnt %0d required 11 3",
                     err_code, err_cnt);
        end
        push(8'hA5); push(8'h22); push(8'h00); push(8'h22);
        for (int i = 0; i < 30; i++) begin
            tick();
            if (cmd_valid) begin
                nv++;
                opc = cmd_opcode;
            end
        end
        checks++;
        if (nv !== 1 || opc !== 8'h22 || pkt_cnt !== 8'd4) begin
            errors++;
            $display("FAIL timeout_recover: got valid %0d opc %0h pkt %0d required 1 22 4",
                     nv, opc, pkt_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        int seen = 0;
        int nv = 0;
        int nw = 0;
        logic [7:0] opc = 8'h00;
        logic [7:0] wd = 8'h00;
        push(8'hA5); push(8'h30); push(8'h04); push(8'h01); push(8'h02);
        for (int i = 0; i < 40 && seen == 0; i++) begin
            tick();
            if (pl_we && pl_data == 8'h02) seen = 1;
        end
        checks++;
        if (seen !== 1) begin
            errors++;
            $display("FAIL rst_mid_reach_pay: got %0d required 1", seen);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({fifo_rd_en, pl_we, pl_addr, pl_data, cmd_valid, cmd_opcode,
             cmd_len, err_pulse, err_code, pkt_cnt, err_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got opc %0h len %0h pkt %0d err %0d required all zero",
                     cmd_opcode, cmd_len, pkt_cnt, err_cnt);
        end
        tick();
        rst = 1'b1;
        tick();
        push(8'hA5); push(8'h31); push(8'h01); push(8'h77); push(8'h47);
        for (int i = 0; i < 40; i++) begin
            tick();
            if (cmd_valid) begin
                nv++;
                opc = cmd_opcode;
            end
            if (pl_we) begin
                nw++;
                wd = pl_data;
            end
        end
        checks++;
        if (nv !== 1 || opc !== 8'h31 || nw !== 1 || wd !== 8'h77 ||
            pkt_cnt !== 8'd1 || err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid_fresh: got valid %0d opc %0h writes %0d data %0h pkt %0d err %0d",
                     nv, opc, nw, wd, pkt_cnt, err_cnt);
        end
    endtask

    task automatic test_err_saturate();
        int ne = 0;
        for (int f = 0; f < 260; f++) begin
            push(8'hA5); push(8'h12); push(8'h11);
        end
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (err_pulse) ne++;
        end
        checks++;
        if (ne !== 260) begin
            errors++;
            $display("FAIL sat_pulses: got %0d required 260", ne);
        end
        checks++;
        if (err_cnt !== 8'hFF || pkt_cnt !== 8'd1) begin
            errors++;
            $display("FAIL sat_errcnt: got err %0h pkt %0d required ff 1", err_cnt, pkt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_back_to_back();
        test_bad_csum();
        test_len_error();
        test_timeout();
        test_reset_mid_frame();
        test_err_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
